// File: rtl/fix2float_pipe.sv
// Signed fixed-point (WIDTH fractional bits, range [-2,2)) to IEEE-754 single.
// Three registered stages: sign/abs, normalise, round-to-nearest-even and pack.
module fix2float_pipe #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH+1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data
);
  localparam int W2 = WIDTH + 2;

  logic v1_reg, v2_reg, v3_reg;
  logic adv1, adv2, adv3;

  assign adv3      = !v3_reg || out_ready;
  assign adv2      = !v2_reg || adv3;
  assign adv1      = !v1_reg || adv2;
  assign in_ready  = adv1;
  assign out_valid = v3_reg;

  // Stage 1: sign and magnitude. -2^(WIDTH+1) negates to itself, which is the correct unsigned magnitude.
  logic          s1_sign_reg;
  logic [W2-1:0] s1_mag_reg;
  logic [W2-1:0] mag_next;

  assign mag_next = in_data[W2-1] ? (~in_data + 1'b1) : in_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_reg      <= 1'b0;
      s1_sign_reg <= 1'b0;
      s1_mag_reg  <= '0;
    end else if (adv1) begin
      v1_reg <= in_valid;
      if (in_valid) begin
        s1_sign_reg <= in_data[W2-1];
        s1_mag_reg  <= mag_next;
      end
    end
  end

  // Stage 2: leading-zero count and normalisation.
  logic [5:0]    lz_next;
  logic          found;
  logic [W2-1:0] norm_next;
  logic [7:0]    exp_next;

  always_comb begin
    lz_next = '0;
    found   = 1'b0;
    for (int i = W2 - 1; i >= 0; i--) begin
      if (!found && s1_mag_reg[i]) begin
        lz_next = 6'(W2 - 1 - i);
        found   = 1'b1;
      end
    end
  end

  assign norm_next = s1_mag_reg << lz_next;
  assign exp_next  = 8'd128 - {2'b00, lz_next};

  logic          s2_sign_reg;
  logic [W2-1:0] s2_norm_reg;
  logic [7:0]    s2_exp_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_reg      <= 1'b0;
      s2_sign_reg <= 1'b0;
      s2_norm_reg <= '0;
      s2_exp_reg  <= '0;
    end else if (adv2) begin
      v2_reg <= v1_reg;
      if (v1_reg) begin
        s2_sign_reg <= s1_sign_reg;
        s2_norm_reg <= norm_next;
        s2_exp_reg  <= exp_next;
      end
    end
  end

  // Stage 3: round and pack. A zero magnitude leaves the normalised MSB clear.
  logic [22:0] frac;
  logic        guard, sticky, round_up;
  logic [23:0] rounded;
  logic [7:0]  exp_rnd;
  logic [31:0] packed_next;

  assign frac  = s2_norm_reg[WIDTH -: 23];
  assign guard = s2_norm_reg[WIDTH-23];

  if (WIDTH > 23) begin : g_sticky
    assign sticky = |s2_norm_reg[WIDTH-24:0];
  end else begin : g_no_sticky
    assign sticky = 1'b0;
  end

  assign round_up    = guard && (sticky || frac[0]);
  assign rounded     = {1'b0, frac} + {23'd0, round_up};
  assign exp_rnd     = s2_exp_reg + {7'd0, rounded[23]};
  assign packed_next = s2_norm_reg[W2-1] ? {s2_sign_reg, exp_rnd, rounded[22:0]} : 32'h0000_0000;

  logic [31:0] out_data_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3_reg       <= 1'b0;
      out_data_reg <= 32'h0000_0000;
    end else if (adv3) begin
      v3_reg <= v2_reg;
      if (v2_reg) out_data_reg <= packed_next;
    end
  end

  assign out_data = out_data_reg;

endmodule

// File: tb/tb_fix2float_pipe.sv
// Bench for fix2float_pipe: directed conversions, backpressure, random streaming
// against an integer-arithmetic IEEE-754 model, and mid-flight asynchronous reset.
module tb_fix2float_pipe;
  localparam int W  = 24;
  localparam int W2 = W + 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W2-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;

  int n_checks = 0;
  int n_errors = 0;
  int out_count = 0;
  logic [31:0] exp_q[$];

  fix2float_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Value = x * 2^-W, rounded to single precision with integer arithmetic (RNE).
  function automatic logic [31:0] ref_f32(input logic [W2-1:0] x);
    logic   s;
    longint a, m, rem, half;
    int     p, sh;
    logic [63:0] mb;
    if (x == '0) return 32'h0;
    s = x[W2-1];
    a = s ? -longint'(signed'(x)) : longint'(x);
    p = 0;
    while ((a >> (p + 1)) != 0) p++;
    if (p > 23) begin
      sh   = p - 23;
      m    = a >> sh;
      rem  = a - (m << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && m[0])) m++;
      if (m == (longint'(1) << 24)) begin
        m = longint'(1) << 23;
        p++;
      end
    end else begin
      m = a << (23 - p);
    end
    mb = 64'(m);
    return {s, 8'(p - W + 127), mb[22:0]};
  endfunction

  // Scoreboard: every accepted input must come out once, in order.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        out_count++;
        if (exp_q.size() == 0) check_eq("spurious_out", 32'(out_valid), 32'h0);
        else check_eq("stream_result", out_data, exp_q.pop_front());
      end
      if (in_valid && in_ready) exp_q.push_back(ref_f32(in_data));
    end
  end

  task automatic send_one(input logic [W2-1:0] d, input logic [31:0] want, input string tag);
    int lat;
    @(posedge clk); #1;
    in_valid  = 1'b1;
    in_data   = d;
    out_ready = 1'b1;
    @(negedge clk);
    check_eq({tag, "_accept"}, 32'(in_ready), 32'h1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) break;
      lat++;
    end
    check_eq({tag, "_latency"}, 32'(lat), 32'd3);
    check_eq(tag, out_data, want);
  endtask

  task automatic drain();
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(negedge clk);
    #1 check_eq("drain_empty", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    int acc, base, waited;
    logic [31:0] held;
    logic [W2-1:0] d;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #12;
    check_eq("reset_out_valid", 32'(out_valid), 32'h0);
    check_eq("reset_out_data", out_data, 32'h0);
    check_eq("reset_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk); #1 rst_n = 1'b1;

    send_one(26'h100_0000, 32'h3F80_0000, "one");
    send_one(26'h300_0000, 32'hBF80_0000, "minus_one");
    send_one(26'h000_0000, 32'h0000_0000, "zero");
    send_one(26'h200_0000, 32'hC000_0000, "minus_two");
    send_one(26'h000_0001, 32'h3380_0000, "lsb");
    send_one(26'h080_0000, 32'h3F00_0000, "half");
    send_one(26'h1FF_FFFF, 32'h4000_0000, "carry_exp");
    send_one(26'h100_0001, 32'h3F80_0000, "tie_even");
    send_one(26'h100_0003, 32'h3F80_0002, "tie_up");
    drain();

    // Backpressure: five offers into a stalled pipe, only three fit.
    @(posedge clk); #1 out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = W2'((i * 37 + 5) << 12);
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check_eq("bp_accepted", 32'(acc), 32'd3);
    @(negedge clk);
    check_eq("bp_in_ready_low", 32'(in_ready), 32'h0);
    check_eq("bp_out_valid", 32'(out_valid), 32'h1);
    held = out_data;
    @(negedge clk);
    check_eq("bp_stable", out_data, held);
    @(posedge clk); #1 out_ready = 1'b1;
    base = out_count;
    #3 check_eq("bp_ready_same_cycle", 32'(in_ready), 32'h1);
    repeat (5) @(negedge clk);
    #1 check_eq("bp_drained", 32'(out_count - base), 32'd3);

    // Random streaming with random backpressure.
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      d = W2'($urandom) >> $urandom_range(0, W2 - 1);
      if ($urandom_range(0, 1) == 1) d = -d;
      in_valid = 1'b1;
      in_data  = d;
      waited = 0;
      forever begin
        out_ready = ($urandom_range(0, 1) == 1);
        @(negedge clk);
        if (in_ready || waited >= 50) break;
        waited++;
        @(posedge clk); #1;
      end
      if (waited >= 50) check_eq("accept_timeout", 32'(in_ready), 32'h1);
    end
    drain();

    // Asynchronous reset with three samples in flight.
    @(posedge clk); #1 out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = W2'(26'h0ABCDE + i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("rst_pre_valid", 32'(out_valid), 32'h1);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check_eq("rst_async_valid", 32'(out_valid), 32'h0);
    check_eq("rst_async_data", out_data, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    out_ready = 1'b1;
    base = out_count;
    repeat (10) @(negedge clk);
    #1 check_eq("rst_no_stale", 32'(out_count - base), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
